// File: rtl/gpio_in_poll_ctrl.sv
// Round-robin poller for single-bit Avalon PIO inputs: debounces each sampled bit,
// tracks stable levels, captures qualified edges and raises a maskable interrupt.
module gpio_in_poll_ctrl #(
    parameter int N_PORTS  = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic [1:0]             pio_address,
    output logic [N_PORTS-1:0]     pio_sel,
    input  logic [32*N_PORTS-1:0]  pio_readdata,
    input  logic [2:0]             csr_address,
    input  logic                   csr_read,
    input  logic                   csr_write,
    input  logic [31:0]            csr_writedata,
    output logic [31:0]            csr_readdata,
    output logic                   irq
);
    // state | meaning
    // IDLE  | waiting for a period tick
    // SEL   | pio_sel drives port idx
    // CAP   | sample port idx, update its debounce/level/edge state
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEL  = 2'd1;
    localparam logic [1:0] ST_CAP  = 2'd2;
    localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [2:0]         ctrl_q;
    logic [15:0]        period_q, timer_q, timer_d;
    logic [N_PORTS-1:0] level_q, level_d, edge_q, edge_d, edge_set, edge_clr, irqmask_q;
    logic               overrun_q, overrun_d;
    logic [7:0]         scan_cnt_q;
    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [3:0]         deb_q [N_PORTS];
    logic [3:0]         deb_d [N_PORTS];
    logic [31:0]        rdata_q, rd_mux;
    logic [N_PORTS-1:0] samp_bits;
    logic               samp, tick, cap, scan_done, busy;
    logic               wr_ctrl, wr_period, wr_edge, wr_irqmask, wr_status;

    assign wr_ctrl    = csr_write && (csr_address == 3'd0);
    assign wr_period  = csr_write && (csr_address == 3'd1);
    assign wr_edge    = csr_write && (csr_address == 3'd3);
    assign wr_irqmask = csr_write && (csr_address == 3'd4);
    assign wr_status  = csr_write && (csr_address == 3'd5);

    assign busy         = (state_q != ST_IDLE);
    assign tick         = ctrl_q[0] && (timer_q == 16'd0);
    assign timer_d      = (!ctrl_q[0] || (timer_q == 16'd0)) ? period_q : (timer_q - 16'd1);
    assign pio_address  = 2'd0;
    assign pio_sel      = (state_q == ST_SEL) ? (N_PORTS'(1) << idx_q) : '0;
    assign csr_readdata = rdata_q;
    assign irq          = |(edge_q & irqmask_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap       = 1'b0;
        scan_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SEL;
                    idx_d   = '0;
                end
            end
            ST_SEL: state_d = ST_CAP;
            ST_CAP: begin
                cap = 1'b1;
                if (idx_q == IW'(N_PORTS - 1)) begin
                    state_d   = ST_IDLE;
                    scan_done = 1'b1;
                end else begin
                    state_d = ST_SEL;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) samp_bits[i] = pio_readdata[32*i];
    end
    assign samp = samp_bits[idx_q];

    always_comb begin
        level_d  = level_q;
        edge_set = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            deb_d[i] = deb_q[i];
            if (cap && (idx_q == IW'(i))) begin
                if (samp == level_q[i]) begin
                    deb_d[i] = 4'd0;
                end else if ((deb_q[i] + 4'd1) == 4'(DEBOUNCE)) begin
                    level_d[i]  = samp;
                    deb_d[i]    = 4'd0;
                    edge_set[i] = samp ? ctrl_q[1] : ctrl_q[2];
                end else begin
                    deb_d[i] = deb_q[i] + 4'd1;
                end
            end
        end
    end

    // Sets take priority over a write-1-to-clear landing in the same cycle.
    assign edge_clr  = wr_edge ? csr_writedata[N_PORTS-1:0] : '0;
    assign edge_d    = (edge_q & ~edge_clr) | edge_set;
    assign overrun_d = (overrun_q & ~(wr_status & csr_writedata[1])) | (tick & busy);

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            3'd0: rd_mux[2:0]         = ctrl_q;
            3'd1: rd_mux[15:0]        = period_q;
            3'd2: rd_mux[N_PORTS-1:0] = level_q;
            3'd3: rd_mux[N_PORTS-1:0] = edge_q;
            3'd4: rd_mux[N_PORTS-1:0] = irqmask_q;
            3'd5: begin
                rd_mux[0]    = busy;
                rd_mux[1]    = overrun_q;
                rd_mux[15:8] = scan_cnt_q;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            period_q   <= 16'h03E8;
            timer_q    <= 16'h03E8;
            level_q    <= '0;
            edge_q     <= '0;
            irqmask_q  <= '0;
            overrun_q  <= 1'b0;
            scan_cnt_q <= '0;
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rdata_q    <= '0;
            for (int i = 0; i < N_PORTS; i++) deb_q[i] <= 4'd0;
        end else begin
            if (wr_ctrl)    ctrl_q    <= csr_writedata[2:0];
            if (wr_period)  period_q  <= csr_writedata[15:0];
            if (wr_irqmask) irqmask_q <= csr_writedata[N_PORTS-1:0];
            if (csr_read)   rdata_q   <= rd_mux;
            if (scan_done)  scan_cnt_q <= scan_cnt_q + 8'd1;
            timer_q   <= timer_d;
            level_q   <= level_d;
            edge_q    <= edge_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            for (int i = 0; i < N_PORTS; i++) deb_q[i] <= deb_d[i];
        end
    end

endmodule

// File: tb/tb_gpio_in_poll_ctrl.sv
// Scoreboard bench for gpio_in_poll_ctrl: CSR reads push expectations into a queue,
// a monitor pops and compares when csr_readdata becomes valid.
module tb_gpio_in_poll_ctrl;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      pio_address;
    logic [N-1:0]    pio_sel;
    logic [32*N-1:0] pio_readdata;
    logic [2:0]      csr_address = '0;
    logic            csr_read = 1'b0;
    logic            csr_write = 1'b0;
    logic [31:0]     csr_writedata = '0;
    logic [31:0]     csr_readdata;
    logic            irq;
    logic [N-1:0]    pins = '0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
    } exp_t;
    exp_t sbq[$];

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  rd_pend = 1'b0;

    gpio_in_poll_ctrl #(.N_PORTS(N), .DEBOUNCE(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pio_address  (pio_address),
        .pio_sel      (pio_sel),
        .pio_readdata (pio_readdata),
        .csr_address  (csr_address),
        .csr_read     (csr_read),
        .csr_write    (csr_write),
        .csr_writedata(csr_writedata),
        .csr_readdata (csr_readdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Only bit 0 of each port word is meaningful; the rest are held high.
    always_comb begin
        for (int i = 0; i < N; i++) pio_readdata[32*i +: 32] = {31'h7FFF_FFFF, pins[i]};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= csr_read;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (sbq.size() == 0) begin
                check("unexpected_read", csr_readdata, 32'hDEAD_BEEF);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                check(x.name, csr_readdata & x.mask, x.exp & x.mask);
            end
        end
    end

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, input logic [31:0] e, input logic [31:0] m,
                          input string nm);
        exp_t x;
        x.name = nm;
        x.exp  = e;
        x.mask = m;
        sbq.push_back(x);
        @(negedge clk);
        csr_address = a;
        csr_read    = 1'b1;
        @(negedge clk);
        csr_read    = 1'b0;
    endtask

    // Returns in the idle cycle after the n-th subsequent scan has fully updated.
    task automatic wait_scans(input int n);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (pio_sel[N-1]) seen++;
        end
        if (seen < n) check("wait_scans_timeout", 32'(seen), 32'(n));
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_sel(input logic [N-1:0] v);
        int cyc = 0;
        while (pio_sel !== v && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (pio_sel !== v) check("wait_sel_timeout", 32'(pio_sel), 32'(v));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          cyc;
        int          nz;
        logic [N-1:0] sel_a, sel_b;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_readdata", csr_readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_pio_sel", 32'(pio_sel), 32'h0);
        check("rst_pio_address", 32'(pio_address), 32'h0);
        csr_rd(3'd0, 32'h0000_0000, 32'hFFFF_FFFF, "rst_ctrl");
        csr_rd(3'd1, 32'h0000_03E8, 32'hFFFF_FFFF, "rst_period");
        csr_rd(3'd2, 32'h0000_0000, 32'hFFFF_FFFF, "rst_level");
        csr_rd(3'd3, 32'h0000_0000, 32'hFFFF_FFFF, "rst_edge");
        csr_rd(3'd4, 32'h0000_0000, 32'hFFFF_FFFF, "rst_irqmask");
        csr_rd(3'd5, 32'h0000_0000, 32'hFFFF_FFFF, "rst_status");

        // Port 2 held high: level and edge after the third scan
        csr_wr(3'd1, 32'd20);
        csr_wr(3'd4, 32'h4);
        pins[2] = 1'b1;
        csr_wr(3'd0, 32'h3);
        csr_rd(3'd0, 32'h0000_0003, 32'hFFFF_FFFF, "ctrl_rb");
        wait_scans(2);
        csr_rd(3'd2, 32'h0, 32'hFFFF_FFFF, "p2_level_scan2");
        csr_rd(3'd3, 32'h0, 32'hFFFF_FFFF, "p2_edge_scan2");
        check("p2_irq_scan2", 32'(irq), 32'h0);
        wait_scans(1);
        csr_rd(3'd2, 32'h4, 32'hFFFF_FFFF, "p2_level_scan3");
        csr_rd(3'd3, 32'h4, 32'hFFFF_FFFF, "p2_edge_scan3");
        check("p2_irq_set", 32'(irq), 32'h1);
        csr_wr(3'd3, 32'h4);
        check("p2_irq_cleared", 32'(irq), 32'h0);
        csr_rd(3'd3, 32'h0, 32'hFFFF_FFFF, "p2_edge_cleared");

        // Glitch on port 1: two high scans then low, repeated
        pins[1] = 1'b1;
        wait_scans(2);
        pins[1] = 1'b0;
        wait_scans(1);
        csr_rd(3'd2, 32'h4, 32'hFFFF_FFFF, "glitch_level");
        csr_rd(3'd3, 32'h0, 32'hFFFF_FFFF, "glitch_edge");
        pins[1] = 1'b1;
        wait_scans(2);
        csr_rd(3'd2, 32'h4, 32'hFFFF_FFFF, "glitch_cnt_restart");
        pins[1] = 1'b0;
        wait_scans(1);
        csr_rd(3'd3, 32'h0, 32'hFFFF_FFFF, "glitch_edge2");

        // Falling-only mode on port 0
        csr_wr(3'd0, 32'h5);
        pins[0] = 1'b1;
        wait_scans(3);
        csr_rd(3'd2, 32'h5, 32'hFFFF_FFFF, "fall_level_hi");
        csr_rd(3'd3, 32'h0, 32'hFFFF_FFFF, "fall_no_rise_edge");
        pins[0] = 1'b0;
        wait_scans(3);
        csr_rd(3'd2, 32'h4, 32'hFFFF_FFFF, "fall_level_lo");
        csr_rd(3'd3, 32'h1, 32'hFFFF_FFFF, "fall_edge");
        check("fall_irq_masked", 32'(irq), 32'h0);
        csr_wr(3'd4, 32'h1);
        check("fall_irq_unmasked", 32'(irq), 32'h1);
        csr_wr(3'd4, 32'h4);
        pins[0] = 1'b1;
        wait_scans(3);
        csr_rd(3'd2, 32'h5, 32'hFFFF_FFFF, "fall_level_hi2");
        pins[0] = 1'b0;
        wait_scans(2);
        // W1C of EDGE[0] in the same cycle as port 0's qualifying CAP
        wait_sel(4'b0001);
        @(negedge clk);
        csr_address   = 3'd3;
        csr_writedata = 32'h1;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
        csr_rd(3'd3, 32'h1, 32'hFFFF_FFFF, "set_beats_clear");
        csr_rd(3'd2, 32'h4, 32'hFFFF_FFFF, "fall_level_lo2");
        wait_scans(1);
        csr_wr(3'd3, 32'h1);
        csr_rd(3'd3, 32'h0, 32'hFFFF_FFFF, "idle_w1c");

        // Overrun with PERIOD=3 and scan ordering
        csr_wr(3'd0, 32'h0);
        csr_wr(3'd1, 32'd3);
        csr_wr(3'd0, 32'h1);
        wait_sel(4'b0001);
        k   = 0;
        cyc = 0;
        while (k < 12 && cyc < 300) begin
            if (pio_sel != '0) begin
                check($sformatf("sel_order%0d", k), 32'(pio_sel), 32'(4'b0001 << (k % 4)));
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        if (k < 12) check("sel_order_timeout", 32'(k), 32'd12);
        csr_rd(3'd5, 32'h2, 32'h2, "overrun_set");
        csr_wr(3'd0, 32'h0);
        repeat (12) @(negedge clk);
        csr_rd(3'd5, 32'h2, 32'h3, "overrun_sticky");
        csr_wr(3'd5, 32'h2);
        csr_rd(3'd5, 32'h0, 32'h3, "overrun_cleared");
        csr_rd(3'd1, 32'h3, 32'hFFFF_FFFF, "period_rb");

        // Reset asserted mid-scan
        csr_wr(3'd0, 32'h1);
        wait_sel(4'b0100);
        reset_n = 1'b0;
        #1;
        check("rst_mid_pio_sel", 32'(pio_sel), 32'h0);
        check("rst_mid_readdata", csr_readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        csr_rd(3'd0, 32'h0, 32'hFFFF_FFFF, "rst_mid_ctrl");
        csr_rd(3'd1, 32'h3E8, 32'hFFFF_FFFF, "rst_mid_period");
        csr_rd(3'd5, 32'h0, 32'hFFFF_FFFF, "rst_mid_status");

        // Disable while port 1 is selected: scan completes, then stays idle
        csr_wr(3'd1, 32'd20);
        csr_wr(3'd0, 32'h1);
        wait_sel(4'b0001);
        csr_rd(3'd5, 32'h1, 32'h1, "busy_in_scan");
        wait_sel(4'b0010);
        csr_address   = 3'd0;
        csr_writedata = 32'h0;
        csr_write     = 1'b1;
        @(negedge clk);
        csr_write     = 1'b0;
        nz    = 0;
        sel_a = '0;
        sel_b = '0;
        repeat (60) begin
            @(negedge clk);
            if (pio_sel != '0) begin
                if (nz == 0) sel_a = pio_sel;
                if (nz == 1) sel_b = pio_sel;
                nz++;
            end
        end
        check("dis_sel_count", 32'(nz), 32'd2);
        check("dis_sel_first", 32'(sel_a), 32'h4);
        check("dis_sel_second", 32'(sel_b), 32'h8);
        csr_rd(3'd5, 32'h0000_0100, 32'hFFFF_FFFF, "dis_status");

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpio_in_poll_ctrl.md
# gpio_in_poll_ctrl

Scan controller for a bank of single-bit Avalon PIO input slaves. It polls each PIO's data register (address 0) in round-robin order on a programmable period. Each sampled bit is debounced, and the block tracks stable levels, captures qualified edges and raises a maskable interrupt. It sits between the PIO input slaves and the Nios, and exposes a small CSR slave so software reads debounced state instead of raw PIO registers.

## Interface
- N_PORTS, 4: number of PIO input slaves scanned (1..8).
- DEBOUNCE, 3: consecutive differing scans required to change a stable level (1..15; 1 = no filtering).
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low; clock clk.
- pio_address  out  2  address broadcast to all PIO slaves; always 0 (data register).
- pio_sel  out  N_PORTS  one-hot index of the port being sampled; 0 when not scanning.
- pio_readdata  in  32*N_PORTS  concatenated PIO readdata; port i occupies bits [32i+31:32i]; only bit 32i is used.
- csr_address  in  3  CSR word address.
- csr_read  in  1  CSR read strobe.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  registered CSR read data.
- irq  out  1  interrupt: |(EDGE & IRQMASK).

## Operation
CSR map (unused bits read 0):
- 0 CTRL (rw, reset 0): bit0 enable; bits[2:1] edge mode, where 00 = none, 01 = rising, 10 = falling, 11 = both.
- 1 PERIOD (rw, reset 0x03E8): bits[15:0], clk cycles between scan starts.
- 2 LEVEL (ro, reset 0): debounced levels [N_PORTS-1:0].
- 3 EDGE (rw1c, reset 0): edge capture bits.
- 4 IRQMASK (rw, reset 0).
- 5 STATUS: bit0 busy (ro); bit1 overrun (sticky, rw1c); bits[15:8] scan count (ro, 8-bit, wraps 0xFF->0x00).

Period timer:
- While enable=1, the timer reloads from PERIOD and counts down; tick fires when it reaches 0, then it reloads.
- While enable=0, the timer holds at PERIOD.
- A PERIOD write takes effect at the next reload.
- PERIOD=0 produces a tick every cycle.

Scan FSM:
- IDLE: tick -> SEL with idx=0, busy=1.
- SEL: pio_sel = 1<<idx -> CAP.
- CAP: sample s = pio_readdata[32*idx], update port idx -> if idx == N_PORTS-1 then IDLE (busy=0, scan count +1), else SEL with idx+1.
- A tick while busy is dropped and sets overrun.
- Clearing enable mid-scan does not abort; the current scan completes and no new tick follows.

Per-port debounce (counter cnt, reset 0):
- s == LEVEL[i]: cnt <- 0.
- s != LEVEL[i] and cnt+1 == DEBOUNCE: LEVEL[i] <- s, cnt <- 0, and an edge qualifies per mode.
- Otherwise: cnt <- cnt+1.

Edge and interrupt rules:
- A qualified edge sets EDGE[i].
- If a set and a write-1-to-clear of EDGE[i] occur in the same cycle, the set wins.
- Same rule applies to overrun vs. its clear.
- irq is combinational from the EDGE and IRQMASK registers.

## Timing
- Reset values: all outputs are 0 (pio_address, pio_sel, csr_readdata, irq), and all CSRs take the reset values listed under Operation.
- Tick at cycle T: SEL for port 0 at T+1, CAP at T+2.
- Port k: SEL at T+1+2k, CAP at T+2+2k.
- Per-port updates become visible one cycle after that port's CAP cycle. This applies to LEVEL, EDGE and irq.
- A full scan takes 2*N_PORTS cycles. busy deasserts the cycle after the last CAP.
- PERIOD+1 < 2*N_PORTS guarantees overrun.
- CSR read: csr_readdata is valid the cycle after csr_read and holds until the next read.
- CSR write takes effect at the clock edge where csr_write is sampled.
- Asserting reset_n low mid-scan immediately forces IDLE, clears all state, and returns all outputs to reset values.

## Test plan
- Reset: after releasing reset_n, reads return CTRL=0, PERIOD=0x000003E8, LEVEL=0, STATUS=0; irq=0; pio_sel=0.
- N_PORTS=4, DEBOUNCE=3, PERIOD=20, CTRL=0x3, IRQMASK=0x4; port 2 input held at 1 -> LEVEL=0x4 and EDGE=0x4 after the third scan; irq=1. Write EDGE=0x4 -> irq=0.
- Glitch: port 1 is 1 for 2 scans, then 0 -> LEVEL and EDGE stay 0; debounce counter returns to 0.
- Falling-only mode (CTRL=0x5): port 0 goes 1->0 after a stable 1 -> EDGE=0x1, with no edge on the prior rise. A W1C of bit0 in the same cycle as a new set leaves EDGE=0x1.
- PERIOD=3 with N_PORTS=4 -> STATUS bit1=1. Every scan still visits ports 0..3 in order; writing STATUS=0x2 clears bit1 when no overrun occurs in that cycle.
- Clear enable while SEL is on port 1 -> ports 2 and 3 still sampled, busy drops, scan count increments once, and pio_sel stays 0 afterward.
